// File: rtl/msx_sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : msx_sdram_arbiter
// Description : Three-way SDRAM arbiter (CPU, flash engine, downloader) with
//               per-grant timeout and sticky error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module msx_sdram_arbiter #(
   parameter int TIMEOUT = 1023
) (
   input  logic        clk,
   input  logic        reset,
   // CPU port
   input  logic        cpu_ce,
   input  logic        cpu_rnw,
   input  logic [26:0] cpu_addr,
   input  logic [7:0]  cpu_din,
   output logic [7:0]  cpu_dout,
   output logic        cpu_wait,
   // flash engine port
   input  logic        fl_req,
   input  logic        fl_rnw,
   input  logic [26:0] fl_addr,
   input  logic [7:0]  fl_din,
   output logic        fl_ready,
   output logic        fl_done,
   output logic [7:0]  fl_dout,
   // download port
   input  logic        dl_wr,
   input  logic [26:0] dl_addr,
   input  logic [7:0]  dl_din,
   output logic        dl_wait,
   // SDRAM controller port
   output logic        sd_req,
   output logic        sd_rnw,
   output logic [26:0] sd_addr,
   output logic [7:0]  sd_din,
   input  logic        sd_ack,
   input  logic [7:0]  sd_dout,
   // status
   output logic        timeout_err,
   output logic        dl_overrun
);

   localparam int               c_CNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

   localparam logic [1:0] c_IDLE    = 2'd0;
   localparam logic [1:0] c_GNT_CPU = 2'd1;
   localparam logic [1:0] c_GNT_FL  = 2'd2;
   localparam logic [1:0] c_GNT_DL  = 2'd3;

   logic [1:0]         r_state;
   logic               r_cpu_pend;
   logic               r_cpu_rnw;
   logic [26:0]        r_cpu_addr;
   logic [7:0]         r_cpu_din;
   logic               r_dl_pend;
   logic [26:0]        r_dl_addr;
   logic [7:0]         r_dl_din;
   logic               r_rr;
   logic [c_CNT_W-1:0] r_cnt;

   logic               w_cpu_req;
   logic               w_cpu_rnw;
   logic [26:0]        w_cpu_addr;
   logic [7:0]         w_cpu_din;
   logic               w_granted;
   logic               w_timeout;
   logic               w_done;
   logic [7:0]         w_rdata;
   logic               w_fl_pick;

   // A fresh strobe is served straight from the port so the grant costs no extra cycle
   assign w_cpu_req  = cpu_ce | r_cpu_pend;
   assign w_cpu_rnw  = r_cpu_pend ? r_cpu_rnw  : cpu_rnw;
   assign w_cpu_addr = r_cpu_pend ? r_cpu_addr : cpu_addr;
   assign w_cpu_din  = r_cpu_pend ? r_cpu_din  : cpu_din;

   assign w_granted  = (r_state != c_IDLE);
   assign w_timeout  = w_granted && !sd_ack && (r_cnt == c_CNT_LAST);
   assign w_done     = w_granted && (sd_ack || w_timeout);
   assign w_rdata    = sd_ack ? sd_dout : 8'hFF;
   assign w_fl_pick  = fl_req && (!r_dl_pend || !r_rr);

   assign cpu_wait   = w_cpu_req;
   assign dl_wait    = r_dl_pend;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= c_IDLE;
         r_cpu_pend  <= 1'b0;
         r_cpu_rnw   <= 1'b1;
         r_cpu_addr  <= '0;
         r_cpu_din   <= '0;
         r_dl_pend   <= 1'b0;
         r_dl_addr   <= '0;
         r_dl_din    <= '0;
         r_rr        <= 1'b0;
         r_cnt       <= '0;
         sd_req      <= 1'b0;
         sd_rnw      <= 1'b1;
         sd_addr     <= '0;
         sd_din      <= '0;
         fl_ready    <= 1'b0;
         fl_done     <= 1'b0;
         cpu_dout    <= 8'hFF;
         fl_dout     <= 8'hFF;
         timeout_err <= 1'b0;
         dl_overrun  <= 1'b0;
      end else begin
         sd_req   <= 1'b0;
         fl_ready <= 1'b0;
         fl_done  <= 1'b0;

         if (cpu_ce && !r_cpu_pend) begin
            r_cpu_pend <= 1'b1;
            r_cpu_rnw  <= cpu_rnw;
            r_cpu_addr <= cpu_addr;
            r_cpu_din  <= cpu_din;
         end else if (w_done && (r_state == c_GNT_CPU)) begin
            r_cpu_pend <= 1'b0;
         end

         if (w_done && (r_state == c_GNT_DL)) begin
            r_dl_pend <= 1'b0;
         end
         if (dl_wr) begin
            if (r_dl_pend) begin
               dl_overrun <= 1'b1;
            end else begin
               r_dl_pend <= 1'b1;
               r_dl_addr <= dl_addr;
               r_dl_din  <= dl_din;
            end
         end

         if (w_timeout) begin
            timeout_err <= 1'b1;
         end

         case (r_state)
            c_IDLE: begin
               r_cnt <= '0;
               if (w_cpu_req) begin
                  r_state <= c_GNT_CPU;
                  sd_req  <= 1'b1;
                  sd_rnw  <= w_cpu_rnw;
                  sd_addr <= w_cpu_addr;
                  sd_din  <= w_cpu_din;
               end else if (w_fl_pick) begin
                  r_state  <= c_GNT_FL;
                  sd_req   <= 1'b1;
                  fl_ready <= 1'b1;
                  sd_rnw   <= fl_rnw;
                  sd_addr  <= fl_addr;
                  sd_din   <= fl_din;
                  r_rr     <= ~r_rr;
               end else if (r_dl_pend) begin
                  r_state <= c_GNT_DL;
                  sd_req  <= 1'b1;
                  sd_rnw  <= 1'b0;
                  sd_addr <= r_dl_addr;
                  sd_din  <= r_dl_din;
                  r_rr    <= ~r_rr;
               end
            end
            default: begin
               r_cnt <= r_cnt + 1'b1;
               if (w_done) begin
                  r_state <= c_IDLE;
                  // A timed-out access completes like an ack carrying 8'hFF
                  if ((r_state == c_GNT_CPU) && sd_rnw) begin
                     cpu_dout <= w_rdata;
                  end
                  if (r_state == c_GNT_FL) begin
                     fl_dout <= w_rdata;
                     fl_done <= 1'b1;
                  end
               end
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_msx_sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_msx_sdram_arbiter
// Description : Scoreboard bench for msx_sdram_arbiter (TIMEOUT = 15).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_msx_sdram_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_ce, cpu_rnw;
   logic [26:0] cpu_addr;
   logic [7:0]  cpu_din, cpu_dout;
   logic        cpu_wait;
   logic        fl_req, fl_rnw;
   logic [26:0] fl_addr;
   logic [7:0]  fl_din, fl_dout;
   logic        fl_ready, fl_done;
   logic        dl_wr;
   logic [26:0] dl_addr;
   logic [7:0]  dl_din;
   logic        dl_wait;
   logic        sd_req, sd_rnw, sd_ack;
   logic [26:0] sd_addr;
   logic [7:0]  sd_din, sd_dout;
   logic        timeout_err, dl_overrun;

   typedef struct packed {
      logic        fl;
      logic        rnw;
      logic [26:0] addr;
      logic [7:0]  din;
   } sd_txn_t;

   sd_txn_t    sd_q[$];
   logic [7:0] fl_q[$];
   sd_txn_t    mon_e;
   logic [7:0] mon_d;
   int         n_checks = 0;
   int         n_errors = 0;

   always #5 clk = ~clk;

   msx_sdram_arbiter #(.TIMEOUT(15)) dut (
      .clk(clk), .reset(reset),
      .cpu_ce(cpu_ce), .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
      .cpu_dout(cpu_dout), .cpu_wait(cpu_wait),
      .fl_req(fl_req), .fl_rnw(fl_rnw), .fl_addr(fl_addr), .fl_din(fl_din),
      .fl_ready(fl_ready), .fl_done(fl_done), .fl_dout(fl_dout),
      .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_din(dl_din), .dl_wait(dl_wait),
      .sd_req(sd_req), .sd_rnw(sd_rnw), .sd_addr(sd_addr), .sd_din(sd_din),
      .sd_ack(sd_ack), .sd_dout(sd_dout),
      .timeout_err(timeout_err), .dl_overrun(dl_overrun)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_sd(input logic fl, input logic rnw, input logic [26:0] a, input logic [7:0] d);
      sd_txn_t t;
      t.fl = fl; t.rnw = rnw; t.addr = a; t.din = d;
      sd_q.push_back(t);
   endtask

   // Holds sd_ack for one cycle after dly further cycles; returns one cycle after the ack.
   task automatic ack_after(input int dly, input logic [7:0] d);
      repeat (dly) tick();
      sd_ack  = 1'b1;
      sd_dout = d;
      tick();
      sd_ack  = 1'b0;
      sd_dout = 8'h00;
   endtask

   task automatic chk_reset_vals();
      chk("rst_sd_req", sd_req, 1'b0);
      chk("rst_fl_ready", fl_ready, 1'b0);
      chk("rst_fl_done", fl_done, 1'b0);
      chk("rst_cpu_wait", cpu_wait, 1'b0);
      chk("rst_dl_wait", dl_wait, 1'b0);
      chk("rst_cpu_dout", cpu_dout, 8'hFF);
      chk("rst_fl_dout", fl_dout, 8'hFF);
      chk("rst_sd_addr", sd_addr, 27'h0);
      chk("rst_sd_din", sd_din, 8'h00);
      chk("rst_sd_rnw", sd_rnw, 1'b1);
      chk("rst_timeout_err", timeout_err, 1'b0);
      chk("rst_dl_overrun", dl_overrun, 1'b0);
   endtask

   // Scoreboard: every SDRAM request and every flash completion must match the queues
   always @(negedge clk) begin
      if (!reset) begin
         if (sd_req) begin
            if (sd_q.size() == 0) begin
               chk("sd_unexpected_req", sd_q.size(), 1);
            end else begin
               mon_e = sd_q.pop_front();
               chk("sb_fl_ready", fl_ready, mon_e.fl);
               chk("sb_sd_rnw", sd_rnw, mon_e.rnw);
               chk("sb_sd_addr", sd_addr, mon_e.addr);
               if (!mon_e.rnw) chk("sb_sd_din", sd_din, mon_e.din);
            end
         end else if (fl_ready) begin
            chk("fl_ready_without_req", fl_ready, 1'b0);
         end
         if (fl_done) begin
            if (fl_q.size() == 0) begin
               chk("fl_unexpected_done", fl_q.size(), 1);
            end else begin
               mon_d = fl_q.pop_front();
               chk("sb_fl_dout", fl_dout, mon_d);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      cpu_ce = 0; cpu_rnw = 1; cpu_addr = '0; cpu_din = '0;
      fl_req = 0; fl_rnw = 1; fl_addr = '0; fl_din = '0;
      dl_wr = 0; dl_addr = '0; dl_din = '0;
      sd_ack = 0; sd_dout = '0;
      repeat (3) tick();
      reset = 1'b0;
      chk_reset_vals();
      tick();

      // CPU read, ack three cycles after the request
      cpu_ce = 1; cpu_rnw = 1; cpu_addr = 27'h0004000; cpu_din = 8'h00;
      push_sd(0, 1, 27'h0004000, 8'h00);
      #1 chk("rd_wait_on_ce", cpu_wait, 1'b1);
      tick();
      cpu_ce = 0;
      chk("rd_sd_req_cycle1", sd_req, 1'b1);
      tick();
      chk("rd_wait_held", cpu_wait, 1'b1);
      chk("rd_addr_held", sd_addr, 27'h0004000);
      ack_after(1, 8'h5A);
      chk("rd_wait_released", cpu_wait, 1'b0);
      chk("rd_cpu_dout", cpu_dout, 8'h5A);

      // CPU write acked in the request cycle; read data must be kept
      cpu_ce = 1; cpu_rnw = 0; cpu_addr = 27'h0000123; cpu_din = 8'hA5;
      push_sd(0, 0, 27'h0000123, 8'hA5);
      tick();
      cpu_ce = 0;
      ack_after(0, 8'h00);
      chk("wr_wait_released", cpu_wait, 1'b0);
      chk("wr_dout_kept", cpu_dout, 8'h5A);

      // Flash and download together: flash first, download second
      fl_req = 1; fl_rnw = 1; fl_addr = 27'h100; fl_din = 8'h00;
      dl_wr = 1; dl_addr = 27'h200; dl_din = 8'h33;
      push_sd(1, 1, 27'h100, 8'h00);
      push_sd(0, 0, 27'h200, 8'h33);
      fl_q.push_back(8'hC3);
      tick();
      dl_wr = 0; fl_req = 0;
      chk("rr_fl_first", fl_ready, 1'b1);
      chk("rr_dl_wait", dl_wait, 1'b1);
      ack_after(1, 8'hC3);
      chk("rr_fl_done", fl_done, 1'b1);
      tick();
      chk("rr_dl_second", sd_req, 1'b1);
      chk("rr_dl_not_fl", fl_ready, 1'b0);
      ack_after(0, 8'h00);
      chk("rr_dl_wait_clear", dl_wait, 1'b0);

      // Lone flash grant leaves the round-robin bit favouring download
      fl_req = 1; fl_addr = 27'h300;
      push_sd(1, 1, 27'h300, 8'h00);
      fl_q.push_back(8'h77);
      tick();
      fl_req = 0;
      chk("solo_fl_ready", fl_ready, 1'b1);
      ack_after(0, 8'h77);
      dl_wr = 1; dl_addr = 27'h210; dl_din = 8'h55;
      tick();
      dl_wr = 0;
      fl_req = 1; fl_addr = 27'h310;
      push_sd(0, 0, 27'h210, 8'h55);
      push_sd(1, 1, 27'h310, 8'h00);
      fl_q.push_back(8'h88);
      tick();
      chk("rr2_dl_first", sd_req, 1'b1);
      chk("rr2_dl_not_fl", fl_ready, 1'b0);
      ack_after(0, 8'h00);
      tick();
      chk("rr2_fl_second", fl_ready, 1'b1);
      fl_req = 0;
      ack_after(0, 8'h88);

      // CPU strobe during a flash grant waits until ack+2
      fl_req = 1; fl_addr = 27'h400;
      push_sd(1, 1, 27'h400, 8'h00);
      push_sd(0, 1, 27'h500, 8'h00);
      fl_q.push_back(8'h99);
      tick();
      fl_req = 0;
      cpu_ce = 1; cpu_rnw = 1; cpu_addr = 27'h500;
      #1 chk("mix_wait_ce", cpu_wait, 1'b1);
      tick();
      cpu_ce = 0;
      chk("mix_wait_pend", cpu_wait, 1'b1);
      ack_after(1, 8'h99);
      chk("mix_fl_done", fl_done, 1'b1);
      chk("mix_wait_idle", cpu_wait, 1'b1);
      chk("mix_no_req_idle", sd_req, 1'b0);
      tick();
      chk("mix_cpu_req_ack2", sd_req, 1'b1);
      chk("mix_wait_gnt", cpu_wait, 1'b1);
      ack_after(1, 8'h66);
      chk("mix_wait_released", cpu_wait, 1'b0);
      chk("mix_cpu_dout", cpu_dout, 8'h66);

      // Timeout on a CPU read, then a stray ack in IDLE
      cpu_ce = 1; cpu_rnw = 1; cpu_addr = 27'h600;
      push_sd(0, 1, 27'h600, 8'h00);
      tick();
      cpu_ce = 0;
      chk("to_req", sd_req, 1'b1);
      repeat (14) tick();
      chk("to_err_not_yet", timeout_err, 1'b0);
      chk("to_wait_held", cpu_wait, 1'b1);
      tick();
      chk("to_err_set", timeout_err, 1'b1);
      chk("to_wait_released", cpu_wait, 1'b0);
      chk("to_cpu_dout", cpu_dout, 8'hFF);
      ack_after(0, 8'h12);
      chk("idle_ack_dout", cpu_dout, 8'hFF);
      chk("idle_ack_no_req", sd_req, 1'b0);

      // Downloads arriving while one is pending are dropped
      dl_wr = 1; dl_addr = 27'h700; dl_din = 8'h11;
      push_sd(0, 0, 27'h700, 8'h11);
      tick();
      dl_addr = 27'h701; dl_din = 8'h22;
      chk("dl_wait_set", dl_wait, 1'b1);
      tick();
      dl_addr = 27'h702; dl_din = 8'h23;
      tick();
      dl_wr = 0;
      chk("dl_overrun_set", dl_overrun, 1'b1);
      ack_after(0, 8'h00);
      chk("dl_wait_clear", dl_wait, 1'b0);
      repeat (4) tick();

      // Reset two cycles into a flash grant, then a stale ack
      fl_req = 1; fl_addr = 27'h800;
      push_sd(1, 1, 27'h800, 8'h00);
      tick();
      fl_req = 0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk_reset_vals();
      ack_after(0, 8'hEE);
      chk("stale_no_done", fl_done, 1'b0);
      chk("stale_no_req", sd_req, 1'b0);
      chk("stale_fl_dout", fl_dout, 8'hFF);
      tick();
      chk("stale_no_done2", fl_done, 1'b0);
      repeat (3) tick();

      chk("sb_sd_drained", sd_q.size(), 0);
      chk("sb_fl_drained", fl_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
